// File: rtl/reg_file_sb.sv
// reg_file_sb: RV32I/RV32E integer register file with two combinational read
// ports decoded from the instruction word, one writeback port, optional
// write-to-read bypass, hardwired-zero x0 and a per-register busy scoreboard.
module reg_file_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter bit BYPASS = 1'b1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst,
  input  logic            issue,
  input  logic            regwr,
  input  logic [4:0]      wraddr,
  input  logic [XLEN-1:0] wrdata,
  output logic [XLEN-1:0] rs1data,
  output logic [XLEN-1:0] rs2data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            hazard,
  output logic [AW:0]     busy_cnt,
  output logic            illegal
);

  // Index fields sit at fixed RV32 positions whatever NREG is.
  logic [4:0] rs1, rs2, rd;
  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];
  assign rd  = inst[11:7];

  // Opcode/funct bits are not needed here; folding them keeps the intent visible.
  logic unused_inst_bits;
  assign unused_inst_bits = &{1'b0, inst[31:25], inst[14:12], inst[6:0]};

  function automatic logic in_range(input logic [4:0] idx);
    return int'(idx) < NREG;
  endfunction

  function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
    logic [AW:0] n;
    n = '0;
    for (int i = 0; i < NREG; i++) n = n + (AW+1)'(v[i]);
    return n;
  endfunction

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     cnt_q, cnt_d;

  logic ok1, ok2, wr_ok, byp1, byp2;
  assign ok1   = (rs1 != 5'd0) && in_range(rs1);
  assign ok2   = (rs2 != 5'd0) && in_range(rs2);
  assign wr_ok = regwr && (wraddr != 5'd0) && in_range(wraddr);
  // A matching writeback this cycle supplies the value and resolves the hazard.
  assign byp1  = BYPASS && regwr && (wraddr == rs1);
  assign byp2  = BYPASS && regwr && (wraddr == rs2);

  // Combinational read ports: x0 and out-of-range indices read zero.
  always_comb begin
    rs1data  = '0;
    rs2data  = '0;
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    if (ok1) begin
      rs1data  = byp1 ? wrdata : regs_q[rs1[AW-1:0]];
      rs1_busy = busy_q[rs1[AW-1:0]] && !byp1;
    end
    if (ok2) begin
      rs2data  = byp2 ? wrdata : regs_q[rs2[AW-1:0]];
      rs2_busy = busy_q[rs2[AW-1:0]] && !byp2;
    end
  end

  assign hazard   = rs1_busy | rs2_busy;
  assign busy_cnt = cnt_q;
  assign illegal  = !in_range(rs1) || !in_range(rs2) ||
                    (issue && !in_range(rd)) || (regwr && !in_range(wraddr));

  // Scoreboard next state: writeback clears first, then a new issue sets, so set wins.
  always_comb begin
    busy_d = busy_q;
    if (regwr && in_range(wraddr)) busy_d[wraddr[AW-1:0]] = 1'b0;
    if (issue && (rd != 5'd0) && in_range(rd)) busy_d[rd[AW-1:0]] = 1'b1;
    cnt_d = popcount(busy_d);
  end

  // Register array: writes to x0 or out-of-range indices are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[wraddr[AW-1:0]] <= wrdata;
    end
  end

  // Busy bits and their registered population count update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: three instances (RV32I bypass, RV32I no bypass,
// RV32E bypass) share one stimulus stream and are compared with an array model.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst, issue, regwr;
  logic [31:0] inst, wrdata;
  logic [4:0]  wraddr;

  logic [31:0] rs1d [3];
  logic [31:0] rs2d [3];
  logic        b1 [3];
  logic        b2 [3];
  logic        hz [3];
  logic        ill [3];
  logic [5:0]  cnt_a, cnt_b;
  logic [4:0]  cnt_e;

  always #5 clk = ~clk;

  reg_file_sb #(.XLEN(32), .NREG(32), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst), .inst(inst), .issue(issue), .regwr(regwr),
    .wraddr(wraddr), .wrdata(wrdata), .rs1data(rs1d[0]), .rs2data(rs2d[0]),
    .rs1_busy(b1[0]), .rs2_busy(b2[0]), .hazard(hz[0]), .busy_cnt(cnt_a),
    .illegal(ill[0]));

  reg_file_sb #(.XLEN(32), .NREG(32), .BYPASS(1'b0)) u_nobyp (
    .clk(clk), .rst(rst), .inst(inst), .issue(issue), .regwr(regwr),
    .wraddr(wraddr), .wrdata(wrdata), .rs1data(rs1d[1]), .rs2data(rs2d[1]),
    .rs1_busy(b1[1]), .rs2_busy(b2[1]), .hazard(hz[1]), .busy_cnt(cnt_b),
    .illegal(ill[1]));

  reg_file_sb #(.XLEN(32), .NREG(16), .BYPASS(1'b1)) u_rv32e (
    .clk(clk), .rst(rst), .inst(inst), .issue(issue), .regwr(regwr),
    .wraddr(wraddr), .wrdata(wrdata), .rs1data(rs1d[2]), .rs2data(rs2d[2]),
    .rs1_busy(b1[2]), .rs2_busy(b2[2]), .hazard(hz[2]), .busy_cnt(cnt_e),
    .illegal(ill[2]));

  // Reference model state per configuration.
  int          nreg [3] = '{32, 32, 16};
  bit          byp  [3] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] mregs [3][32];
  bit          mbusy [3][32];

  int npass = 0;
  int nchk  = 0;

  function automatic logic [31:0] mk(input int r1, input int r2, input int d);
    logic [4:0] a, b, c;
    a = 5'(r1); b = 5'(r2); c = 5'(d);
    return {7'd0, b, a, 3'd0, c, 7'h33};
  endfunction

  function automatic logic [31:0] exp_read(input int c, input int idx);
    if (idx == 0 || idx >= nreg[c]) return 32'd0;
    if (byp[c] && regwr && int'(wraddr) == idx) return wrdata;
    return mregs[c][idx];
  endfunction

  function automatic logic exp_busy(input int c, input int idx);
    if (idx == 0 || idx >= nreg[c]) return 1'b0;
    return mbusy[c][idx] && !(byp[c] && regwr && int'(wraddr) == idx);
  endfunction

  function automatic int exp_cnt(input int c);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(mbusy[c][i]);
    return n;
  endfunction

  function automatic int dut_cnt(input int c);
    if (c == 0) return int'(cnt_a);
    if (c == 1) return int'(cnt_b);
    return int'(cnt_e);
  endfunction

  task automatic check_all(input string tag);
    int r1, r2, d, n;
    logic [31:0] e1, e2;
    logic eb1, eb2, eil;
    r1 = int'(inst[19:15]); r2 = int'(inst[24:20]); d = int'(inst[11:7]);
    for (int c = 0; c < 3; c++) begin
      n   = nreg[c];
      e1  = exp_read(c, r1);
      e2  = exp_read(c, r2);
      eb1 = exp_busy(c, r1);
      eb2 = exp_busy(c, r2);
      eil = (r1 >= n) || (r2 >= n) || (issue && d >= n) || (regwr && int'(wraddr) >= n);
      nchk++;
      assert (rs1d[c] === e1) npass++;
      else $error("FAIL %s.rs1data cfg%0d got %h want %h", tag, c, rs1d[c], e1);
      nchk++;
      assert (rs2d[c] === e2) npass++;
      else $error("FAIL %s.rs2data cfg%0d got %h want %h", tag, c, rs2d[c], e2);
      nchk++;
      assert (b1[c] === eb1) npass++;
      else $error("FAIL %s.rs1_busy cfg%0d got %b want %b", tag, c, b1[c], eb1);
      nchk++;
      assert (b2[c] === eb2) npass++;
      else $error("FAIL %s.rs2_busy cfg%0d got %b want %b", tag, c, b2[c], eb2);
      nchk++;
      assert (hz[c] === (eb1 | eb2)) npass++;
      else $error("FAIL %s.hazard cfg%0d got %b want %b", tag, c, hz[c], eb1 | eb2);
      nchk++;
      assert (ill[c] === eil) npass++;
      else $error("FAIL %s.illegal cfg%0d got %b want %b", tag, c, ill[c], eil);
      nchk++;
      assert (dut_cnt(c) === exp_cnt(c)) npass++;
      else $error("FAIL %s.busy_cnt cfg%0d got %0d want %0d", tag, c, dut_cnt(c), exp_cnt(c));
    end
  endtask

  // Apply the architectural effect of one clock edge to the model.
  task automatic model_edge();
    int d, w;
    d = int'(inst[11:7]); w = int'(wraddr);
    for (int c = 0; c < 3; c++) begin
      if (rst) begin
        for (int i = 0; i < 32; i++) begin
          mregs[c][i] = 32'd0;
          mbusy[c][i] = 1'b0;
        end
      end else begin
        if (regwr && w != 0 && w < nreg[c]) mregs[c][w] = wrdata;
        if (regwr && w < nreg[c]) mbusy[c][w] = 1'b0;
        if (issue && d != 0 && d < nreg[c]) mbusy[c][d] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step(input string tag);
    #3;
    check_all(tag);
    tick();
  endtask

  task automatic idle();
    rst = 1'b0; issue = 1'b0; regwr = 1'b0; wraddr = 5'd0; wrdata = 32'd0;
  endtask

  initial begin
    idle();
    rst  = 1'b1;
    inst = mk(0, 0, 0);
    tick();
    step("reset_hold");

    // x0 stays zero even when written.
    idle(); regwr = 1'b1; wraddr = 5'd0; wrdata = 32'hFFFF_FFFF; inst = mk(0, 0, 0);
    step("x0_write");
    idle(); inst = mk(0, 0, 0);
    step("x0_read");

    // Write/read with bypass versus no bypass.
    idle(); regwr = 1'b1; wraddr = 5'd6; wrdata = 32'hDEAD_BEEF; inst = mk(6, 7, 0);
    step("bypass_same");
    idle(); inst = mk(6, 7, 0);
    step("bypass_next");

    // Scoreboard set then clear by writeback.
    idle(); issue = 1'b1; inst = mk(0, 0, 2);
    step("sb_issue");
    idle(); inst = mk(2, 0, 0);
    step("sb_busy");
    regwr = 1'b1; wraddr = 5'd2; wrdata = 32'd5;
    step("sb_clear");
    idle(); inst = mk(2, 0, 0);
    step("sb_after");

    // Same-edge set and clear on x3: set wins.
    idle(); issue = 1'b1; inst = mk(0, 0, 3);
    step("ss_issue");
    issue = 1'b1; regwr = 1'b1; wraddr = 5'd3; wrdata = 32'h33; inst = mk(3, 0, 3);
    step("ss_both");
    idle(); inst = mk(3, 0, 0);
    step("ss_after");

    // Reset in the middle of outstanding producers.
    idle(); issue = 1'b1; inst = mk(0, 0, 1); step("mr_i1");
    issue = 1'b1; inst = mk(0, 0, 2); step("mr_i2");
    issue = 1'b1; inst = mk(0, 0, 5); regwr = 1'b1; wraddr = 5'd4; wrdata = 32'h1234_5678;
    step("mr_i5");
    idle(); inst = mk(4, 1, 0); step("mr_pre");
    rst = 1'b1; issue = 1'b1; inst = mk(4, 9, 9); step("mr_rst");
    idle(); inst = mk(4, 9, 0); step("mr_post");

    // Out-of-range indices for the RV32E instance.
    idle(); issue = 1'b1; inst = mk(0, 0, 7); step("e_prep");
    idle(); inst = mk(7, 20, 0); step("e_rs2");
    regwr = 1'b1; wraddr = 5'd17; wrdata = 32'd1; step("e_wr17");
    idle(); inst = mk(1, 17, 0); step("e_after");
    issue = 1'b1; inst = mk(0, 0, 18); step("e_rd18");

    // Randomized traffic with occasional reset.
    for (int k = 0; k < 400; k++) begin
      idle();
      rst    = ($urandom_range(0, 39) == 0);
      issue  = $urandom_range(0, 1) == 1;
      regwr  = $urandom_range(0, 1) == 1;
      wrdata = $urandom;
      inst   = $urandom;
      wraddr = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) wraddr = inst[19:15];
      else if ($urandom_range(0, 3) == 0) wraddr = inst[24:20];
      step("rand");
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
